// File: rtl/alu_share_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_if
// Description : Bundle of the command, ALU and response signals around the
//               shared-ALU controller.
//               slave  - controller view (takes commands and ALU results,
//                        drives grants, ALU inputs and responses).
//               master - environment view (requesters, ALU and consumer).
// Signals     : req0/req1 valid, ready, Number1, Number2, printout;
//               alu_Number1/2, alu_printout, alu_conclusion, alu_balancebit;
//               resp_valid, resp_ready, resp_id, resp_conclusion,
//               resp_balancebit, resp_err; busy.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_share_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [4:0]  req0_Number1;
  logic [4:0]  req0_Number2;
  logic [5:0]  req0_printout;

  logic        req1_valid;
  logic        req1_ready;
  logic [4:0]  req1_Number1;
  logic [4:0]  req1_Number2;
  logic [5:0]  req1_printout;

  logic [4:0]  alu_Number1;
  logic [4:0]  alu_Number2;
  logic [5:0]  alu_printout;
  logic [31:0] alu_conclusion;
  logic        alu_balancebit;

  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [31:0] resp_conclusion;
  logic        resp_balancebit;
  logic        resp_err;

  logic        busy;

  modport slave (
    input  req0_valid, req0_Number1, req0_Number2, req0_printout,
    input  req1_valid, req1_Number1, req1_Number2, req1_printout,
    input  alu_conclusion, alu_balancebit, resp_ready,
    output req0_ready, req1_ready,
    output alu_Number1, alu_Number2, alu_printout,
    output resp_valid, resp_id, resp_conclusion, resp_balancebit, resp_err,
    output busy
  );

  modport master (
    output req0_valid, req0_Number1, req0_Number2, req0_printout,
    output req1_valid, req1_Number1, req1_Number2, req1_printout,
    output alu_conclusion, alu_balancebit, resp_ready,
    input  req0_ready, req1_ready,
    input  alu_Number1, alu_Number2, alu_printout,
    input  resp_valid, resp_id, resp_conclusion, resp_balancebit, resp_err,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_ctrl
// Description : Round-robin arbiter and sequencer for the shared ALU. Grants
//               one of two requesters, holds the ALU inputs for SETTLE_CYCLES
//               cycles, captures result and balance bit, and returns them
//               tagged with the requester ID. Function code 6'b000000 is
//               rejected with an error response without touching the ALU.
// Ports       : clk   - system clock, rising edge
//               reset - synchronous active-high reset
//               bus   - alu_share_if.slave (requests, ALU, response, busy)
// Parameters  : SETTLE_CYCLES - ALU hold cycles before capture, 1..15
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  wire logic   clk,
  input  wire logic   reset,
  alu_share_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic [3:0] C_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [5:0] C_NOP_CODE    = 6'b000000;

  state_t      state_q;
  logic        last_grant_q;
  logic [3:0]  cnt_q;
  logic [4:0]  alu_n1_q;
  logic [4:0]  alu_n2_q;
  logic [5:0]  alu_op_q;
  logic        resp_id_q;
  logic [31:0] resp_conc_q;
  logic        resp_bb_q;
  logic        resp_err_q;

  logic        w_grant0;
  logic        w_grant1;
  logic [4:0]  w_n1;
  logic [4:0]  w_n2;
  logic [5:0]  w_op;

  // On a tie the requester that did not win last time is granted; the two
  // terms are mutually exclusive by construction.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!reset && (state_q == S_IDLE)) begin
      w_grant0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
      w_grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
    end
    w_n1 = w_grant1 ? bus.req1_Number1  : bus.req0_Number1;
    w_n2 = w_grant1 ? bus.req1_Number2  : bus.req0_Number2;
    w_op = w_grant1 ? bus.req1_printout : bus.req0_printout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= 4'd0;
      alu_n1_q     <= 5'd0;
      alu_n2_q     <= 5'd0;
      alu_op_q     <= C_NOP_CODE;
      resp_id_q    <= 1'b0;
      resp_conc_q  <= 32'd0;
      resp_bb_q    <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_grant0 || w_grant1) begin
            last_grant_q <= w_grant1;
            resp_id_q    <= w_grant1;
            if (w_op == C_NOP_CODE) begin
              // Illegal command: answer immediately, ALU inputs stay at no-op.
              state_q     <= S_RESP;
              resp_err_q  <= 1'b1;
              resp_conc_q <= 32'd0;
              resp_bb_q   <= 1'b0;
            end else begin
              state_q    <= S_ISSUE;
              cnt_q      <= C_SETTLE_LOAD;
              alu_n1_q   <= w_n1;
              alu_n2_q   <= w_n2;
              alu_op_q   <= w_op;
              resp_err_q <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          if (cnt_q == 4'd0) begin
            resp_conc_q <= bus.alu_conclusion;
            resp_bb_q   <= bus.alu_balancebit;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          // ALU inputs stay at the last code throughout RESP so latching
          // units keep their value; they return to no-op only in IDLE.
          if (bus.resp_ready) begin
            state_q  <= S_IDLE;
            alu_n1_q <= 5'd0;
            alu_n2_q <= 5'd0;
            alu_op_q <= C_NOP_CODE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req0_ready      = w_grant0;
  assign bus.req1_ready      = w_grant1;
  assign bus.alu_Number1     = alu_n1_q;
  assign bus.alu_Number2     = alu_n2_q;
  assign bus.alu_printout    = alu_op_q;
  assign bus.resp_valid      = (state_q == S_RESP);
  assign bus.resp_id         = resp_id_q;
  assign bus.resp_conclusion = resp_conc_q;
  assign bus.resp_balancebit = resp_bb_q;
  assign bus.resp_err        = resp_err_q;
  assign bus.busy            = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_ctrl
// Description : Directed bench for alu_share_ctrl. Instance A uses
//               SETTLE_CYCLES=1, instance B uses SETTLE_CYCLES=4; both share
//               clk and reset. A small behavioural ALU answers each instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_share_if ifa ();
  alu_share_if ifb ();

  alu_share_ctrl #(.SETTLE_CYCLES(1)) u_dut_a (.clk(clk), .reset(reset), .bus(ifa));
  alu_share_ctrl #(.SETTLE_CYCLES(4)) u_dut_b (.clk(clk), .reset(reset), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: 100000 -> unsigned max, 000001 -> sign-extend Number1,
  // anything else -> XOR. Balance bit = Number1 > Number2.
  function automatic logic [32:0] alu_model(input logic [4:0] a, input logic [4:0] b,
                                            input logic [5:0] op);
    logic [31:0] r;
    case (op)
      6'b100000: r = (a > b) ? {27'd0, a} : {27'd0, b};
      6'b000001: r = {{27{a[4]}}, a};
      default:   r = {27'd0, a ^ b};
    endcase
    return {(a > b), r};
  endfunction

  always_comb begin
    {ifa.alu_balancebit, ifa.alu_conclusion} = alu_model(ifa.alu_Number1, ifa.alu_Number2, ifa.alu_printout);
    {ifb.alu_balancebit, ifb.alu_conclusion} = alu_model(ifb.alu_Number1, ifb.alu_Number2, ifb.alu_printout);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int          gcount;
  int          rcount;
  int          first_g;
  int          last_g;
  int          gid   [4];
  int          rid   [4];
  logic [31:0] rconc [4];
  int          vcount;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    ifa.req0_valid = 1'b0; ifa.req0_Number1 = 5'd0; ifa.req0_Number2 = 5'd0; ifa.req0_printout = 6'd0;
    ifa.req1_valid = 1'b0; ifa.req1_Number1 = 5'd0; ifa.req1_Number2 = 5'd0; ifa.req1_printout = 6'd0;
    ifa.resp_ready = 1'b0;
    ifb.req0_valid = 1'b0; ifb.req0_Number1 = 5'd0; ifb.req0_Number2 = 5'd0; ifb.req0_printout = 6'd0;
    ifb.req1_valid = 1'b0; ifb.req1_Number1 = 5'd0; ifb.req1_Number2 = 5'd0; ifb.req1_printout = 6'd0;
    ifb.resp_ready = 1'b0;
    repeat (2) @(negedge clk);

    // ---- reset state ----
    check("rst_resp_valid", {31'd0, ifa.resp_valid}, 0);
    check("rst_busy", {31'd0, ifa.busy}, 0);
    check("rst_alu_printout", {26'd0, ifa.alu_printout}, 0);
    check("rst_alu_n1", {27'd0, ifa.alu_Number1}, 0);
    check("rst_resp_fields", {ifa.resp_id, ifa.resp_err, ifa.resp_balancebit}, 0);
    check("rst_resp_conclusion", ifa.resp_conclusion, 0);
    ifa.req0_valid = 1'b1; ifa.req0_Number1 = 5'd9; ifa.req0_Number2 = 5'd3; ifa.req0_printout = 6'b100000;
    #1 check("rst_no_ready", {31'd0, ifa.req0_ready}, 0);

    // ---- test 1: single req0, SETTLE_CYCLES=1 ----
    @(negedge clk);
    reset = 1'b0;
    #1 check("t1_grant", {30'd0, ifa.req1_ready, ifa.req0_ready}, 32'd1);
    @(negedge clk);
    ifa.req0_valid = 1'b0;
    check("t1_issue_busy", {31'd0, ifa.busy}, 1);
    check("t1_issue_noresp", {31'd0, ifa.resp_valid}, 0);
    check("t1_issue_alu", {16'd0, ifa.alu_Number1, ifa.alu_Number2, ifa.alu_printout}, {16'd0, 5'd9, 5'd3, 6'b100000});
    @(negedge clk);
    check("t1_resp_valid", {31'd0, ifa.resp_valid}, 1);
    check("t1_resp_id_err_bb", {29'd0, ifa.resp_id, ifa.resp_err, ifa.resp_balancebit}, 32'd1);
    check("t1_resp_conclusion", ifa.resp_conclusion, 32'd9);
    ifa.resp_ready = 1'b1;
    @(negedge clk);
    check("t1_back_idle", {30'd0, ifa.busy, ifa.resp_valid}, 0);
    check("t1_idle_alu_nop", {26'd0, ifa.alu_printout}, 0);

    // ---- test 2: round robin from a fresh reset ----
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ifa.req0_valid = 1'b1; ifa.req0_Number1 = 5'd1; ifa.req0_Number2 = 5'd2; ifa.req0_printout = 6'b100000;
    ifa.req1_valid = 1'b1; ifa.req1_Number1 = 5'd7; ifa.req1_Number2 = 5'd4; ifa.req1_printout = 6'b100000;
    gcount = 0; rcount = 0; first_g = -1; last_g = -1;
    for (int c = 0; c < 40 && rcount < 4; c++) begin
      #1;
      check("t2_one_hot", {31'd0, ifa.req0_ready & ifa.req1_ready}, 0);
      if ((ifa.req0_ready || ifa.req1_ready) && gcount < 4) begin
        gid[gcount] = ifa.req1_ready ? 1 : 0;
        if (gcount == 0) first_g = c;
        if (gcount == 3) last_g = c;
        gcount++;
      end
      if (ifa.resp_valid && rcount < 4) begin
        rid[rcount]   = int'(ifa.resp_id);
        rconc[rcount] = ifa.resp_conclusion;
        rcount++;
      end
      @(negedge clk);
    end
    ifa.req0_valid = 1'b0;
    ifa.req1_valid = 1'b0;
    check("t2_grant_count", gcount, 4);
    check("t2_resp_count", rcount, 4);
    check("t2_grant_order", {gid[0][7:0], gid[1][7:0], gid[2][7:0], gid[3][7:0]}, 32'h00010001);
    check("t2_resp_id_order", {rid[0][7:0], rid[1][7:0], rid[2][7:0], rid[3][7:0]}, 32'h00010001);
    check("t2_conc0", rconc[0], 32'd2);
    check("t2_conc1", rconc[1], 32'd7);
    check("t2_conc3", rconc[3], 32'd7);
    check("t2_throughput", last_g - first_g, 9);

    // ---- test 3: illegal op on req1 ----
    ifa.resp_ready = 1'b0;
    ifa.req1_valid = 1'b1; ifa.req1_Number1 = 5'd5; ifa.req1_Number2 = 5'd6; ifa.req1_printout = 6'b000000;
    #1 check("t3_grant1", {30'd0, ifa.req1_ready, ifa.req0_ready}, 32'd2);
    check("t3_alu_nop_t", {26'd0, ifa.alu_printout}, 0);
    @(negedge clk);
    ifa.req1_valid = 1'b0;
    check("t3_resp_valid", {31'd0, ifa.resp_valid}, 1);
    check("t3_resp_err_id", {30'd0, ifa.resp_err, ifa.resp_id}, 32'd3);
    check("t3_resp_conclusion", ifa.resp_conclusion, 0);
    check("t3_alu_not_driven", {16'd0, ifa.alu_Number1, ifa.alu_Number2, ifa.alu_printout}, 0);

    // ---- test 4: backpressure with req0 pending ----
    ifa.req0_valid = 1'b1; ifa.req0_Number1 = 5'd12; ifa.req0_Number2 = 5'd20; ifa.req0_printout = 6'b100000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_hold_valid", {31'd0, ifa.resp_valid}, 1);
      check("t4_hold_fields", {29'd0, ifa.resp_err, ifa.resp_id, ifa.resp_balancebit}, 32'd6);
      check("t4_hold_conclusion", ifa.resp_conclusion, 0);
      check("t4_no_grant", {30'd0, ifa.req1_ready, ifa.req0_ready}, 0);
      check("t4_alu_nop", {26'd0, ifa.alu_printout}, 0);
    end
    ifa.resp_ready = 1'b1;
    @(negedge clk);
    #1 check("t4_grant_after_hs", {30'd0, ifa.resp_valid, ifa.req0_ready}, 32'd1);
    @(negedge clk);
    ifa.req0_valid = 1'b0;
    check("t4_issue_alu", {16'd0, ifa.alu_Number1, ifa.alu_Number2, ifa.alu_printout}, {16'd0, 5'd12, 5'd20, 6'b100000});
    @(negedge clk);
    check("t4_resp_valid", {31'd0, ifa.resp_valid}, 1);
    check("t4_resp_conclusion", ifa.resp_conclusion, 32'd20);
    check("t4_resp_id_err_bb", {29'd0, ifa.resp_id, ifa.resp_err, ifa.resp_balancebit}, 0);
    @(negedge clk);

    // ---- test 5: SETTLE_CYCLES=4, sign-extended result passed through ----
    ifb.resp_ready = 1'b0;
    ifb.req0_valid = 1'b1; ifb.req0_Number1 = 5'b10110; ifb.req0_Number2 = 5'b00001; ifb.req0_printout = 6'b000001;
    #1 check("t5_grant", {31'd0, ifb.req0_ready}, 1);
    check("t5_alu_idle", {26'd0, ifb.alu_printout}, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ifb.req0_valid = 1'b0;
      check("t5_issue_noresp", {30'd0, ifb.busy, ifb.resp_valid}, 32'd2);
      check("t5_issue_alu", {16'd0, ifb.alu_Number1, ifb.alu_Number2, ifb.alu_printout}, {16'd0, 5'b10110, 5'b00001, 6'b000001});
    end
    @(negedge clk);
    check("t5_resp_valid", {31'd0, ifb.resp_valid}, 1);
    check("t5_resp_conclusion", ifb.resp_conclusion, 32'hFFFFFFF6);
    check("t5_resp_id_err_bb", {29'd0, ifb.resp_id, ifb.resp_err, ifb.resp_balancebit}, 32'd1);
    ifb.resp_ready = 1'b1;
    @(negedge clk);
    check("t5_back_idle", {16'd0, ifb.alu_Number1, ifb.alu_Number2, ifb.alu_printout}, 0);

    // ---- test 6: reset in second ISSUE cycle ----
    ifb.req0_valid = 1'b1; ifb.req0_Number1 = 5'd3; ifb.req0_Number2 = 5'd4; ifb.req0_printout = 6'b100000;
    #1 check("t6_grant", {31'd0, ifb.req0_ready}, 1);
    @(negedge clk);
    ifb.req0_valid = 1'b0;
    @(negedge clk);
    check("t6_in_issue", {26'd0, ifb.alu_printout}, {26'd0, 6'b100000});
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_state", {30'd0, ifb.busy, ifb.resp_valid}, 0);
    check("t6_rst_alu", {16'd0, ifb.alu_Number1, ifb.alu_Number2, ifb.alu_printout}, 0);
    reset = 1'b0;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ifb.resp_valid) vcount++;
    end
    check("t6_no_response", vcount, 0);
    ifb.req0_valid = 1'b1; ifb.req0_Number1 = 5'd11; ifb.req0_Number2 = 5'd1;
    ifb.req1_valid = 1'b1; ifb.req1_Number1 = 5'd2;  ifb.req1_Number2 = 5'd1; ifb.req1_printout = 6'b100000;
    #1 check("t6_tie_req0", {30'd0, ifb.req1_ready, ifb.req0_ready}, 32'd1);
    @(negedge clk);
    ifb.req0_valid = 1'b0;
    ifb.req1_valid = 1'b0;
    check("t6_tie_alu_n1", {27'd0, ifb.alu_Number1}, 32'd11);
    check("t6_tie_resp_id", {31'd0, ifb.resp_id}, 0);
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Two-requester round-robin arbiter and sequencer for the shared ALU datapath: the 5-bit operand units (`greater` and its siblings), selected by a 6-bit function code. It accepts operation commands over a valid/ready handshake, holds the ALU inputs stable for a programmable settle window and captures the 32-bit result and balance bit. It returns each result with its requester ID on a single response channel. It sits between the two command sources (datapath control and test/debug port) and the combinational ALU.

## Interface
- `SETTLE_CYCLES`, default 1: cycles the ALU inputs are held before capture; legal range 1–15.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req0_valid` / `req1_valid` input 1: the requester has a command.
- `req0_ready` / `req1_ready` output 1: the command is accepted this cycle.
- `req0_Number1`, `req0_Number2`, `req1_Number1`, `req1_Number2` input 5: operands.
- `req0_printout` / `req1_printout` input 6: ALU function code.
- `alu_Number1` / `alu_Number2` output 5: operands driven to the ALU.
- `alu_printout` output 6: function code driven to the ALU.
- `alu_conclusion` input 32: ALU result.
- `alu_balancebit` input 1: ALU parity/balance bit.
- `resp_valid` output 1: a response is available.
- `resp_ready` input 1: the consumer takes the response.
- `resp_id` output 1: requester that issued the command (0 or 1).
- `resp_conclusion` output 32: captured result.
- `resp_balancebit` output 1: captured balance bit.
- `resp_err` output 1: the command was rejected as illegal.
- `busy` output 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE**
  - Arbitrate among the valid requesters.
  - With one valid request, grant it. With both valid, grant the requester not granted last.
  - `last_grant` resets to 1, so req0 wins the first tie.
  - Grant means the corresponding `reqN_ready` = 1 combinationally in the same cycle. It is never asserted outside IDLE, and never asserted for both requesters in the same cycle.
  - On grant, latch the operands, function code and ID into command registers and update `last_grant`.
  - If the latched function code is 6'b000000, go directly to RESP with `resp_err`=1 and `resp_conclusion`=0. The ALU is not driven.
  - Otherwise go to ISSUE.
- **ISSUE**
  - `alu_*` outputs are driven from the command registers and stay stable for the whole state.
  - The settle counter loads SETTLE_CYCLES−1 on entry and decrements each cycle.
  - In the cycle the counter is 0, capture `alu_conclusion` and `alu_balancebit` into the response registers and go to RESP.
- **RESP**
  - `resp_valid`=1, and all `resp_*` fields are held constant.
  - When `resp_valid` && `resp_ready`, go to IDLE. No new grant is made in that same cycle.
  - `alu_printout` is held at the last code so the latching ALU units keep their value.
- **Outside ISSUE and RESP:** `alu_Number1`/`alu_Number2` = 0 and `alu_printout` = 6'b000000 (no-op code), so the ALU units retain their state.
- **Width rules:** operands and results pass through unmodified; no sign extension or parity is computed here.
- **Requester obligations:** `reqN_valid` and its fields stay stable until ready. Dropping `reqN_valid` before grant is permitted and simply withdraws the request.
- **Reset**
  - Effective on any clock edge, including mid-ISSUE or mid-RESP. The in-flight command is discarded and no response is produced.
  - Reset values: state IDLE, `last_grant`=1, all `resp_*` = 0, `resp_valid`=0, `busy`=0, `alu_*` = 0, both `reqN_ready` = 0 while `reset` is high.

## Timing
- **Accept to response:** command accepted in cycle T (ready && valid) → ISSUE cycles T+1..T+SETTLE_CYCLES → `resp_valid` rises at T+1+SETTLE_CYCLES.
- **Illegal op:** `resp_valid` rises at T+1.
- **Throughput:** with `resp_ready` held high, one command per SETTLE_CYCLES+2 cycles. IDLE always lasts at least one cycle between commands.
- **Response backpressure:** `resp_valid` is held indefinitely while `resp_ready`=0. Requests stay pending and are not granted.
- **Capture point:** the capture samples the ALU outputs at the rising edge that ends the last ISSUE cycle.

## Test plan
1. Single req0: Number1=5'd9, Number2=5'd3, printout=6'b100000, SETTLE_CYCLES=1, ALU model returns max → `resp_valid` at T+2 with `resp_id`=0, `resp_conclusion`=32'd9, `resp_balancebit`=1, `resp_err`=0.
2. Both requesters valid continuously, `resp_ready`=1, four commands → grants in order 0,1,0,1, `resp_id` sequence 0,1,0,1, never both readies high in one cycle.
3. Illegal op: req1 printout=6'b000000 → `resp_valid` at T+1 with `resp_err`=1, `resp_conclusion`=0, `resp_id`=1. `alu_printout` stays 6'b000000 throughout.
4. Backpressure: `resp_ready`=0 for 10 cycles after `resp_valid` with req0 pending → response fields stable and `req0_ready`=0 throughout. Grant occurs one cycle after the response handshake.
5. SETTLE_CYCLES=4, Number1=5'b10110, Number2=5'b00001 → `alu_*` stable for exactly 4 cycles. `resp_conclusion`=32'hFFFFFFF6 (ALU sign-extended value passed through unchanged), latency 5 cycles.
6. Reset asserted in the second ISSUE cycle → next cycle state IDLE, `busy`=0, `resp_valid`=0, `alu_*`=0. No response is ever produced for the dropped command, and the next tie grants req0.
